// File: rtl/unary_pkg.sv
// Shared types for the unary stream array: FSM state, per-lane sign/magnitude record
// and the two's-complement to sign-magnitude split used at load time.
package unary_pkg;

    // Operand width carried by the lane record; the top-level WIDTH must match it.
    localparam int UNARY_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic                   sign;
        logic [UNARY_WIDTH-1:0] mag;
    } lane_t;

    // The most-negative operand maps to 2^(W-1), which still fits the unsigned field.
    function automatic lane_t to_sign_mag(input logic signed [UNARY_WIDTH-1:0] value);
        lane_t                  r;
        logic [UNARY_WIDTH-1:0] raw;
        raw    = value;
        r.sign = value[UNARY_WIDTH-1];
        r.mag  = r.sign ? (~raw + 1'b1) : raw;
        return r;
    endfunction

endpackage

// File: rtl/unary_lane.sv
// One unary lane: shadow magnitude for replays, a live down-counter and the operand sign.
// The lane output stays high while the live count is nonzero.
module unary_lane
    import unary_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  clear,
    input  logic  load,
    input  lane_t load_val,
    input  logic  reload,
    input  logic  dec,
    output logic  nonzero,
    output logic  neg
);

    logic                   sign_r;
    logic [UNARY_WIDTH-1:0] shadow_mag;
    logic [UNARY_WIDTH-1:0] live_mag;

    // NOTE: state updates are non-blocking so every lane samples the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sign_r     <= 1'b0;
            shadow_mag <= '0;
            live_mag   <= '0;
        end else if (load) begin
            sign_r     <= load_val.sign;
            shadow_mag <= load_val.mag;
            live_mag   <= load_val.mag;
        end else if (reload) begin
            live_mag <= shadow_mag;
        end else if (dec && nonzero) begin
            live_mag <= live_mag - 1'b1;
        end
    end

    assign nonzero = |live_mag;
    assign neg     = sign_r & nonzero;

endmodule

// File: rtl/unary_stream_array.sv
// DIM-lane sign-plus-unary stream generator with load handshake, replay count and flush.
// Optional macro UNARY_PREFETCH_EN adds a one-deep prefetch slot for back-to-back jobs.
module unary_stream_array
    import unary_pkg::*;
#(
    parameter int DIM      = 4,
    parameter int WIDTH    = UNARY_WIDTH,
    parameter int REPEAT_W = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIM-1:0][WIDTH-1:0] in_array,
    input  logic [REPEAT_W-1:0]       in_repeat,
    input  logic                      en,
    input  logic                      flush,
    output logic [DIM-1:0]            unary_out,
    output logic [DIM-1:0]            neg,
    output logic                      pass_done,
    output logic                      done,
    output logic                      busy
);

    state_t              state;
    state_t              next_state;
    logic [REPEAT_W-1:0] pass_cnt;
    logic [REPEAT_W-1:0] repeat_r;
    logic [REPEAT_W-1:0] src_repeat;
    lane_t [DIM-1:0]     in_lanes;
    lane_t [DIM-1:0]     src_lanes;

    logic fire;
    logic all_zero;
    logic terminal;
    logic final_pass;
    logic restart;
    logic run_ready;
    logic next_avail;
    logic lane_load;
    logic lane_reload;
    logic lane_dec;
    logic lane_clear;

    assign fire        = in_valid & in_ready;
    assign all_zero    = ~|unary_out;
    assign final_pass  = (pass_cnt == repeat_r);
    // Flush wins over the terminal decision, so a flushed pass never reports completion.
    assign terminal    = (state == RUN) & all_zero & ~flush;
    assign restart     = terminal & final_pass & next_avail;
    assign lane_clear  = (state == RUN) & flush;
    assign lane_load   = ((state == IDLE) & fire) | restart;
    assign lane_reload = terminal & ~final_pass;
    assign lane_dec    = (state == RUN) & en;

    for (genvar i = 0; i < DIM; i++) begin : g_lane
        assign in_lanes[i] = to_sign_mag(in_array[i]);

        unary_lane u_lane (
            .clk      (clk),
            .reset    (reset),
            .clear    (lane_clear),
            .load     (lane_load),
            .load_val (src_lanes[i]),
            .reload   (lane_reload),
            .dec      (lane_dec),
            .nonzero  (unary_out[i]),
            .neg      (neg[i])
        );
    end

`ifdef UNARY_PREFETCH_EN
    logic                pf_valid;
    lane_t [DIM-1:0]     pf_lanes;
    logic [REPEAT_W-1:0] pf_repeat;

    // A handshake on the final terminal cycle with an empty slot loads the lanes directly.
    always_ff @(posedge clk) begin
        if (reset || lane_clear) begin
            pf_valid  <= 1'b0;
            pf_lanes  <= '0;
            pf_repeat <= '0;
        end else if ((state == RUN) && fire && !restart) begin
            pf_valid  <= 1'b1;
            pf_lanes  <= in_lanes;
            pf_repeat <= in_repeat;
        end else if (restart) begin
            pf_valid <= 1'b0;
        end
    end

    assign run_ready  = ~pf_valid & ~flush;
    assign next_avail = pf_valid | fire;
    assign src_lanes  = pf_valid ? pf_lanes : in_lanes;
    assign src_repeat = pf_valid ? pf_repeat : in_repeat;
`else
    assign run_ready  = 1'b0;
    assign next_avail = 1'b0;
    assign src_lanes  = in_lanes;
    assign src_repeat = in_repeat;
`endif

    always_ff @(posedge clk) begin
        if (reset || lane_clear) begin
            pass_cnt <= '0;
            repeat_r <= '0;
        end else if (lane_load) begin
            pass_cnt <= '0;
            repeat_r <= src_repeat;
        end else if (lane_reload) begin
            pass_cnt <= pass_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (fire) next_state = RUN;
            RUN: begin
                if (flush) begin
                    next_state = IDLE;
                end else if (terminal && final_pass && !restart) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        pass_done = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            RUN: begin
                busy      = 1'b1;
                in_ready  = run_ready;
                pass_done = terminal;
                done      = terminal & final_pass;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_unary_stream_array.sv
// Self-checking bench for unary_stream_array: fixed vector table, hand-written corner
// sequences and randomized jobs compared against an enabled-cycle-count reference model.
module tb_unary_stream_array;

    localparam int DIM      = 4;
    localparam int WIDTH    = 8;
    localparam int REPEAT_W = 4;
`ifdef UNARY_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      in_valid;
    logic                      in_ready;
    logic [DIM-1:0][WIDTH-1:0] in_array;
    logic [REPEAT_W-1:0]       in_repeat;
    logic                      en;
    logic                      flush;
    logic [DIM-1:0]            unary_out;
    logic [DIM-1:0]            neg;
    logic                      pass_done;
    logic                      done;
    logic                      busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int vals[DIM];
        int rep;
        int exp_high[DIM];
        int exp_neg[DIM];
        int exp_done_cyc;
        int exp_passes;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    unary_stream_array #(.DIM(DIM), .WIDTH(WIDTH), .REPEAT_W(REPEAT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_array  (in_array),
        .in_repeat (in_repeat),
        .en        (en),
        .flush     (flush),
        .unary_out (unary_out),
        .neg       (neg),
        .pass_done (pass_done),
        .done      (done),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_vals(input int vals[DIM]);
        for (int i = 0; i < DIM; i++) in_array[i] = WIDTH'(vals[i]);
    endtask

    function automatic vec_t mk(input int v0, v1, v2, v3, rep, h0, h1, h2, h3,
                                n0, n1, n2, n3, dc, np);
        vec_t r;
        r.vals[0] = v0; r.vals[1] = v1; r.vals[2] = v2; r.vals[3] = v3;
        r.exp_high[0] = h0; r.exp_high[1] = h1; r.exp_high[2] = h2; r.exp_high[3] = h3;
        r.exp_neg[0] = n0; r.exp_neg[1] = n1; r.exp_neg[2] = n2; r.exp_neg[3] = n3;
        r.rep = rep;
        r.exp_done_cyc = dc;
        r.exp_passes = np;
        return r;
    endfunction

    // Accept one table vector with en=1, count lane activity until done, compare totals.
    task automatic run_vec(input vec_t v, input int idx);
        int high[DIM];
        int negc[DIM];
        int passes;
        int done_cyc;
        for (int i = 0; i < DIM; i++) begin
            high[i] = 0;
            negc[i] = 0;
        end
        passes   = 0;
        done_cyc = -1;
        drive_vals(v.vals);
        in_repeat = REPEAT_W'(v.rep);
        in_valid  = 1'b1;
        en        = 1'b1;
        #3;
        check($sformatf("vec%0d_accept", idx), in_ready, 1);
        next_cycle();
        in_valid = 1'b0;
        for (int t = 1; t <= 4000 && done_cyc < 0; t++) begin
            #3;
            for (int i = 0; i < DIM; i++) begin
                if (unary_out[i]) high[i]++;
                if (neg[i]) negc[i]++;
            end
            if (pass_done) passes++;
            if (done) begin
                done_cyc = t;
                check($sformatf("vec%0d_done_with_pass_done", idx), pass_done, 1);
            end
            next_cycle();
        end
        for (int i = 0; i < DIM; i++) begin
            check($sformatf("vec%0d_lane%0d_high", idx, i), high[i], v.exp_high[i]);
            check($sformatf("vec%0d_lane%0d_neg", idx, i), negc[i], v.exp_neg[i]);
        end
        check($sformatf("vec%0d_passes", idx), passes, v.exp_passes);
        check($sformatf("vec%0d_done_cycle", idx), done_cyc, v.exp_done_cyc);
        #3;
        check($sformatf("vec%0d_idle_after", idx), {busy, in_ready, unary_out}, {1'b0, 1'b1, 4'h0});
        next_cycle();
    endtask

    // Reference: lane i is high while the number of enabled cycles spent in this pass is
    // below |v_i|; the pass ends on the first cycle that count reaches the largest |v|.
    task automatic run_model(input int vals[DIM], input int rep, input int en_mode, input string tag);
        int mag[DIM];
        int m;
        int e;
        int p;
        bit fin;
        bit term;
        int t;
        logic [DIM-1:0] exp_u;
        logic [DIM-1:0] exp_n;
        m = 0;
        for (int i = 0; i < DIM; i++) begin
            mag[i] = (vals[i] < 0) ? -vals[i] : vals[i];
            if (mag[i] > m) m = mag[i];
        end
        e   = 0;
        p   = 0;
        fin = 1'b0;
        t   = 0;
        drive_vals(vals);
        in_repeat = REPEAT_W'(rep);
        in_valid  = 1'b1;
        en        = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        while (!fin && t < 2000) begin
            t++;
            case (en_mode)
                0:       en = 1'b1;
                1:       en = (t % 2 == 1);
                default: en = ($urandom_range(3) != 0);
            endcase
            #3;
            for (int i = 0; i < DIM; i++) begin
                exp_u[i] = (e < mag[i]);
                exp_n[i] = exp_u[i] & (vals[i] < 0);
            end
            term = (e >= m);
            check($sformatf("%s_t%0d", tag, t), {unary_out, neg, pass_done, done, busy, in_ready},
                  {exp_u, exp_n, term, term && (p == rep), 1'b1, PF});
            if (term) begin
                if (p == rep) fin = 1'b1;
                else begin
                    p++;
                    e = 0;
                end
            end else if (en) begin
                e++;
            end
            next_cycle();
        end
        check({tag, "_finished"}, fin, 1);
        en = 1'b1;
        #3;
        check({tag, "_idle"}, {busy, in_ready, unary_out, pass_done, done}, {1'b0, 1'b1, 4'h0, 2'b00});
        next_cycle();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int va[DIM];
        int rep;
        reset     = 1'b1;
        in_valid  = 1'b0;
        en        = 1'b0;
        flush     = 1'b0;
        in_array  = '0;
        in_repeat = '0;
        repeat (2) next_cycle();
        reset = 1'b0;
        #3;
        check("reset_in_ready", in_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_unary_out", unary_out, 0);
        check("reset_neg", neg, 0);
        check("reset_pass_done", pass_done, 0);
        check("reset_done", done, 0);
        next_cycle();

        tbl.push_back(mk(3, -2, 0, 5, 0,   3, 2, 0, 5,   0, 2, 0, 0,   6, 1));
        tbl.push_back(mk(-128, 127, 0, 0, 0,   128, 127, 0, 0,   128, 0, 0, 0,   129, 1));
        tbl.push_back(mk(2, 1, 0, 0, 2,   6, 3, 0, 0,   0, 0, 0, 0,   9, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0,   0, 0, 0, 0,   0, 0, 0, 0,   1, 1));
        tbl.push_back(mk(-1, -1, -1, -1, 1,   2, 2, 2, 2,   2, 2, 2, 2,   4, 2));
        tbl.push_back(mk(-5, 5, -7, 0, 3,   20, 20, 28, 0,   20, 0, 28, 0,   32, 4));
        foreach (tbl[k]) run_vec(tbl[k], k);

        va = '{4, 4, 4, 4};
        run_model(va, 0, 1, "en_toggle");

        // Flush on cycle 2 of a 5-cycle pass.
        va = '{4, 0, -3, 0};
        drive_vals(va);
        in_repeat = '0;
        in_valid  = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        #3;
        check("flush_mid_t1", {unary_out, neg}, {4'b0101, 4'b0100});
        next_cycle();
        flush = 1'b1;
        #3;
        check("flush_mid_no_done", {pass_done, done}, 2'b00);
        next_cycle();
        flush = 1'b0;
        #3;
        check("flush_mid_idle", {busy, in_ready, unary_out, neg, pass_done, done},
              {1'b0, 1'b1, 4'h0, 4'h0, 2'b00});
        next_cycle();
        va = '{3, -2, 0, 5};
        run_model(va, 0, 0, "post_flush");

        // Flush landing on the terminal cycle suppresses completion.
        va = '{1, 0, 0, 0};
        drive_vals(va);
        in_valid = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        next_cycle();
        flush = 1'b1;
        #3;
        check("flush_term", {unary_out, pass_done, done}, {4'h0, 2'b00});
        next_cycle();
        flush = 1'b0;
        #3;
        check("flush_term_idle", {busy, in_ready}, 2'b01);
        next_cycle();

        // Flush in IDLE does not block the handshake.
        va = '{2, 0, 0, 0};
        drive_vals(va);
        in_valid = 1'b1;
        flush    = 1'b1;
        #3;
        check("idle_flush_ready", in_ready, 1);
        next_cycle();
        in_valid = 1'b0;
        flush    = 1'b0;
        #3;
        check("idle_flush_t1", {busy, unary_out}, {1'b1, 4'b0001});
        next_cycle();
        #3;
        check("idle_flush_t2", {unary_out, done}, {4'b0001, 1'b0});
        next_cycle();
        #3;
        check("idle_flush_t3_done", {pass_done, done}, 2'b11);
        next_cycle();

        // Reset beats flush and the handshake mid-run.
        va = '{3, 3, 3, 3};
        drive_vals(va);
        in_valid = 1'b1;
        next_cycle();
        reset = 1'b1;
        flush = 1'b1;
        next_cycle();
        reset    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        #3;
        check("reset_beats_all", {busy, in_ready, unary_out, neg}, {1'b0, 1'b1, 4'h0, 4'h0});
        next_cycle();

`ifdef UNARY_PREFETCH_EN
        // B fills the slot mid-run, C stalls until B is promoted with no idle gap.
        va = '{3, -2, 0, 5};
        drive_vals(va);
        in_repeat = '0;
        in_valid  = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        next_cycle();
        va = '{1, 1, 1, 1};
        drive_vals(va);
        in_valid = 1'b1;
        #3;
        check("pf_b_ready", in_ready, 1);
        next_cycle();
        va = '{2, 2, 2, 2};
        drive_vals(va);
        for (int t = 3; t <= 6; t++) begin
            #3;
            check($sformatf("pf_c_stall_t%0d", t), in_ready, 0);
            if (t == 6) check("pf_a_done", {pass_done, done}, 2'b11);
            next_cycle();
        end
        #3;
        check("pf_b_nogap", {busy, unary_out, neg}, {1'b1, 4'hF, 4'h0});
        check("pf_c_ready", in_ready, 1);
        next_cycle();
        in_valid = 1'b0;
        #3;
        check("pf_b_done", {pass_done, done, in_ready}, 3'b110);
        next_cycle();
        for (int t = 9; t <= 10; t++) begin
            #3;
            check($sformatf("pf_c_t%0d", t), {unary_out, done}, {4'hF, 1'b0});
            next_cycle();
        end
        #3;
        check("pf_c_done", {unary_out, done}, {4'h0, 1'b1});
        next_cycle();
        #3;
        check("pf_idle", {busy, in_ready}, 2'b01);
        next_cycle();
`endif

        for (int j = 0; j < 30; j++) begin
            for (int i = 0; i < DIM; i++) begin
                case ($urandom_range(0, 15))
                    0:       va[i] = -128;
                    1:       va[i] = 127;
                    default: va[i] = int'($urandom_range(0, 40)) - 20;
                endcase
            end
            rep = int'($urandom_range(0, 3));
            run_model(va, rep, 2, $sformatf("rand%0d", j));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
